// File: rtl/sa_autosa_sdp_wdma_pkg.sv
// Shared constants and encodings for the SDP write-DMA request builder.
package sa_autosa_sdp_wdma_pkg;

    localparam int DW_DEF   = 256;
    localparam int AW_DEF   = 64;
    localparam int LENW_DEF = 13;

    // Header layout for the default geometry: addr, then len, then require_ack.
    localparam int ADDR_LSB = 0;
    localparam int LEN_LSB  = ADDR_LSB + AW_DEF;
    localparam int ACK_BIT  = LEN_LSB + LENW_DEF;

    typedef enum logic {
        REQ_HDR = 1'b0,
        REQ_DAT = 1'b1
    } req_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

endpackage

// File: rtl/sa_autosa_sdp_wdma_req_pipe.sv
// Single-entry valid/ready output register holding {last, type, pd}.
module sa_autosa_sdp_wdma_req_pipe #(
    parameter int W = 258
) (
    input  logic         autosa_core_clk,
    input  logic         autosa_core_rst,
    input  logic         in_load,
    input  logic [W-1:0] in_data,
    output logic         out_free,
    output logic         out_pvld,
    input  logic         out_prdy,
    output logic [W-1:0] out_data
);

    assign out_free = !out_pvld || out_prdy;

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            out_pvld <= 1'b0;
            // NOTE: the payload is one register, not a memory; clearing it keeps type/pd at 0 after reset.
            out_data <= '0;
        end else if (in_load && out_free) begin
            out_pvld <= 1'b1;
            out_data <= in_data;
        end else if (out_prdy) begin
            out_pvld <= 1'b0;
        end
    end

endmodule

// File: rtl/sa_autosa_sdp_wdma_req.sv
// Turns one command plus len+1 packed beats into a header beat followed by data beats.
module sa_autosa_sdp_wdma_req
    import sa_autosa_sdp_wdma_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int LENW = LENW_DEF
) (
    input  logic            autosa_core_clk,
    input  logic            autosa_core_rst,
    input  logic            cmd_pvld,
    output logic            cmd_prdy,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [LENW-1:0] cmd_len,
    input  logic            cmd_require_ack,
    input  logic            dat_pvld,
    output logic            dat_prdy,
    input  logic [DW-1:0]   dat_data,
    output logic            dma_wr_req_pvld,
    input  logic            dma_wr_req_prdy,
    output logic            dma_wr_req_type,
    output logic [DW-1:0]   dma_wr_req_pd,
    output logic            op_done,
    output logic            busy
);

    localparam int HDR_LEN_LSB = ADDR_LSB + AW;
    localparam int HDR_ACK_BIT = HDR_LEN_LSB + LENW;

    state_e            state;
    logic [LENW-1:0]   beat_cnt;
    logic              out_free;
    logic              out_last;
    logic              cmd_acc;
    logic              dat_acc;
    logic [DW-1:0]     hdr;
    logic [DW+1:0]     load_word;
    logic [DW+1:0]     out_word;

    // Handshakes are gated by reset so nothing is taken while the block is held.
    assign cmd_prdy = !autosa_core_rst && (state == ST_IDLE) && out_free;
    assign dat_prdy = !autosa_core_rst && (state == ST_DATA) && out_free;
    assign cmd_acc  = cmd_pvld && cmd_prdy;
    assign dat_acc  = dat_pvld && dat_prdy;
    assign busy     = !autosa_core_rst && ((state != ST_IDLE) || dma_wr_req_pvld);

    always_comb begin
        // NOTE: assign the whole vector first so unfilled header bits can never infer a latch.
        hdr                            = '0;
        hdr[ADDR_LSB +: AW]            = cmd_addr;
        hdr[HDR_LEN_LSB +: LENW]       = cmd_len;
        hdr[HDR_ACK_BIT]               = cmd_require_ack;
    end

    assign load_word = cmd_acc ? {1'b0, logic'(REQ_HDR), hdr}
                               : {(beat_cnt == '0), logic'(REQ_DAT), dat_data};

    sa_autosa_sdp_wdma_req_pipe #(
        .W (DW + 2)
    ) u_pipe (
        .autosa_core_clk (autosa_core_clk),
        .autosa_core_rst (autosa_core_rst),
        .in_load         (cmd_acc || dat_acc),
        .in_data         (load_word),
        .out_free        (out_free),
        .out_pvld        (dma_wr_req_pvld),
        .out_prdy        (dma_wr_req_prdy),
        .out_data        (out_word)
    );

    assign dma_wr_req_pd   = out_word[DW-1:0];
    assign dma_wr_req_type = out_word[DW];
    assign out_last        = out_word[DW+1];

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            op_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop here samples pre-edge values.
            op_done <= dma_wr_req_pvld && dma_wr_req_prdy && out_last;
            case (state)
                ST_IDLE: begin
                    if (cmd_acc) begin
                        beat_cnt <= cmd_len;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (dat_acc) begin
                        if (beat_cnt == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
